// File: rtl/lora_frame_tx.sv
// rtl/lora_frame_tx.sv - framed, sequence-numbered, checksummed LoRa UART transmitter
module lora_frame_tx #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter int          N_FIELDS  = 4,
    parameter int          PERIOD_MS = 1000,
    parameter logic [7:0]  HDR       = 8'hA5,
    parameter int          GAP_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [8*N_FIELDS-1:0]   payload,
    input  logic                    must_tx,
    input  logic                    rx_tick,
    output logic                    lora_tx,
    output logic                    busy,
    output logic                    lora_tx_tick,
    output logic [7:0]              frame_cnt
);

    localparam int          BIT_CYC  = CLK_FREQ / BAUD;
    localparam logic [31:0] BIT_END  = 32'(BIT_CYC - 1);
    localparam logic [31:0] GAP_END  = 32'(GAP_BITS * BIT_CYC - 1);
    localparam bit          HB_ON    = (PERIOD_MS != 0);
    localparam logic [31:0] HB_MAX   = HB_ON ? 32'(PERIOD_MS * (CLK_FREQ / 1000) - 1) : 32'd0;
    // Byte list is HDR, SEQ, payload bytes, CHK; this is the index of CHK.
    localparam logic [4:0]  LAST_IDX = 5'(N_FIELDS + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [31:0]             cnt;
    logic [2:0]              bit_idx;
    logic [4:0]              byte_idx;
    logic [7:0]              seq;
    logic [7:0]              chk;
    logic [8*N_FIELDS-1:0]   snapshot;
    logic                    pending;
    logic [31:0]             hb_cnt;
    logic                    ms_s1;
    logic                    ms_s2;
    logic                    ms_d;
    logic [7:0]              cur_byte;
    logic [7:0]              payload_xor;

    logic bit_done;
    logic gap_done;
    logic must_edge;
    logic change;
    logic hb_expire;
    logic trigger;

    assign bit_done  = (cnt == BIT_END);
    assign gap_done  = (cnt == GAP_END);
    assign must_edge = ms_s2 & ~ms_d;
    // Change detect only while idle: a mid-frame change that reverts before the gap ends is ignored.
    assign change    = (state_q == S_IDLE) && (payload != snapshot);
    assign hb_expire = HB_ON && enable && (state_q == S_IDLE) && (hb_cnt == HB_MAX);
    assign trigger   = must_edge | rx_tick | change | hb_expire;
    assign busy      = (state_q != S_IDLE);

    // Select the byte currently being serialised from the frame byte list.
    always_comb begin
        cur_byte = HDR;
        if (byte_idx == 5'd1) begin
            cur_byte = seq;
        end else if (byte_idx == LAST_IDX) begin
            cur_byte = chk;
        end else begin
            for (int k = 0; k < N_FIELDS; k++) begin
                if (byte_idx == 5'(k + 2)) begin
                    cur_byte = snapshot[8*k +: 8];
                end
            end
        end
    end

    // XOR of all payload bytes, folded with SEQ into CHK at LOAD.
    always_comb begin
        payload_xor = 8'h00;
        for (int k = 0; k < N_FIELDS; k++) begin
            payload_xor = payload_xor ^ payload[8*k +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and serial line drive.
    always_comb begin
        state_d = state_q;
        lora_tx = 1'b1;
        case (state_q)
            S_IDLE:  if (pending && enable) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: begin
                lora_tx = 1'b0;
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                lora_tx = cur_byte[bit_idx];
                if (bit_done && (bit_idx == 3'd7)) state_d = S_STOP;
            end
            S_STOP:  if (bit_done) state_d = (byte_idx == LAST_IDX) ? S_GAP : S_START;
            S_GAP:   if (gap_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Synchronise the asynchronous forced-send request before edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_s1 <= 1'b0;
            ms_s2 <= 1'b0;
            ms_d  <= 1'b0;
        end else begin
            ms_s1 <= must_tx;
            ms_s2 <= ms_s1;
            ms_d  <= ms_s2;
        end
    end

    // Bit/gap timing plus bit and byte position within the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 32'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 5'd0;
        end else begin
            if ((state_d != state_q) || (state_q == S_DATA && bit_done) ||
                (state_q == S_IDLE) || (state_q == S_LOAD)) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end
            if (state_q == S_LOAD || state_q == S_START) begin
                bit_idx <= 3'd0;
            end else if (state_q == S_DATA && bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (state_q == S_LOAD) begin
                byte_idx <= 5'd0;
            end else if (state_q == S_STOP && bit_done) begin
                byte_idx <= byte_idx + 5'd1;
            end
        end
    end

    // Frame bookkeeping: snapshot and checksum at LOAD, sequence and counters at gap exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot     <= '0;
            chk          <= 8'h00;
            seq          <= 8'h00;
            frame_cnt    <= 8'h00;
            lora_tx_tick <= 1'b0;
        end else begin
            lora_tx_tick <= 1'b0;
            if (state_q == S_LOAD) begin
                snapshot <= payload;
                chk      <= seq ^ payload_xor;
            end
            if (state_q == S_GAP && gap_done) begin
                lora_tx_tick <= 1'b1;
                frame_cnt    <= frame_cnt + 8'd1;
                seq          <= seq + 8'd1;
            end
        end
    end

    // Coalesce triggers into one pending bit; a trigger during LOAD re-arms it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else begin
            pending <= ((state_q == S_LOAD) ? 1'b0 : pending) | trigger;
        end
    end

    // Heartbeat counter runs only while idle and enabled, restarting at each LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_cnt <= 32'd0;
        end else if (!enable || state_q == S_LOAD) begin
            hb_cnt <= 32'd0;
        end else if (state_q == S_IDLE) begin
            hb_cnt <= (hb_cnt == HB_MAX) ? 32'd0 : hb_cnt + 32'd1;
        end
    end

endmodule
